// File: rtl/cacheline_adaptor.sv
// Bridges one 256-bit cacheline read/write from the miss arbiter onto a 4-beat x 64-bit memory burst.
// A simultaneous read+write serves the read first and keeps the write pending internally.
module cacheline_adaptor #(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [ADDR_WIDTH-1:0]  cache_addr_i,
  input  logic [LINE_WIDTH-1:0]  cache_wdata_i,
  input  logic                   cache_read_i,
  input  logic                   cache_write_i,
  output logic [LINE_WIDTH-1:0]  cache_rdata_o,
  output logic                   cache_resp_o,
  output logic [ADDR_WIDTH-1:0]  pmem_address_o,
  output logic                   pmem_read_o,
  output logic                   pmem_write_o,
  output logic [BURST_WIDTH-1:0] pmem_wdata_o,
  input  logic [BURST_WIDTH-1:0] pmem_rdata_i,
  input  logic                   pmem_resp_i
);
  localparam int BEATS = LINE_WIDTH / BURST_WIDTH;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFS   = $clog2(LINE_WIDTH / 8);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_e;
  typedef logic [BEATS-1:0][BURST_WIDTH-1:0] line_t;

  state_e                 state_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  line_t                  line_q, rdata_q, wline_d;
  logic [BURST_WIDTH-1:0] wdata_q;
  logic                   rd_q, wr_q, resp_q, wr_pend_q;
  logic                   addr_unused;

  // Offset bits inside the line are dropped by design.
  assign addr_unused = ^cache_addr_i[OFS-1:0];
  assign addr_d      = {cache_addr_i[ADDR_WIDTH-1:OFS], {OFS{1'b0}}};
  assign wline_d     = line_t'(cache_wdata_i);
  assign cnt_d       = cnt_q + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      line_q    <= '0;
      rdata_q   <= '0;
      wdata_q   <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      resp_q    <= 1'b0;
      wr_pend_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (cache_read_i) begin
            state_q <= RD_BURST;
            rd_q    <= 1'b1;
            addr_q  <= addr_d;
            // Capture a concurrent write now; the requester may drop it later.
            if (cache_write_i) begin
              wr_pend_q <= 1'b1;
              line_q    <= wline_d;
            end
          end else if (wr_pend_q) begin
            state_q   <= WR_BURST;
            wr_q      <= 1'b1;
            wr_pend_q <= 1'b0;
            wdata_q   <= line_q[0];
          end else if (cache_write_i) begin
            state_q <= WR_BURST;
            wr_q    <= 1'b1;
            addr_q  <= addr_d;
            line_q  <= wline_d;
            wdata_q <= wline_d[0];
          end
        end
        RD_BURST: begin
          if (pmem_resp_i) begin
            rdata_q[cnt_q] <= pmem_rdata_i;
            cnt_q          <= cnt_d;
            if (cnt_q == LAST) begin
              state_q <= DONE;
              rd_q    <= 1'b0;
              resp_q  <= 1'b1;
            end
          end
        end
        WR_BURST: begin
          if (pmem_resp_i) begin
            cnt_q   <= cnt_d;
            wdata_q <= line_q[cnt_d];
            if (cnt_q == LAST) begin
              state_q <= DONE;
              wr_q    <= 1'b0;
              resp_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          resp_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cache_rdata_o  = rdata_q;
  assign cache_resp_o   = resp_q;
  assign pmem_address_o = addr_q;
  assign pmem_read_o    = rd_q;
  assign pmem_write_o   = wr_q;
  assign pmem_wdata_o   = wdata_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: queued expected lines/beats are popped and
// compared as the adaptor produces bursts and responses.
module tb_cacheline_adaptor;
  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  cache_addr;
  logic [255:0] cache_wdata;
  logic         cache_read, cache_write;
  logic [255:0] cache_rdata;
  logic         cache_resp;
  logic [31:0]  pmem_address;
  logic         pmem_read, pmem_write;
  logic [63:0]  pmem_wdata, pmem_rdata;
  logic         pmem_resp;

  int n_assert = 0;
  int n_fail   = 0;

  logic [63:0]  rbeat_q[$];
  logic [63:0]  wexp_q[$];
  logic [255:0] rline_q[$];

  always #5 clk = ~clk;

  cacheline_adaptor dut (
    .clk_i(clk), .rst_i(rst),
    .cache_addr_i(cache_addr), .cache_wdata_i(cache_wdata),
    .cache_read_i(cache_read), .cache_write_i(cache_write),
    .cache_rdata_o(cache_rdata), .cache_resp_o(cache_resp),
    .pmem_address_o(pmem_address), .pmem_read_o(pmem_read), .pmem_write_o(pmem_write),
    .pmem_wdata_o(pmem_wdata), .pmem_rdata_i(pmem_rdata), .pmem_resp_i(pmem_resp)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [255:0] mkline(input logic [63:0] b0, b1, b2, b3);
    return {b3, b2, b1, b0};
  endfunction

  task automatic push_read(input logic [255:0] line);
    rline_q.push_back(line);
    for (int i = 0; i < 4; i++) rbeat_q.push_back(line[64*i +: 64]);
  endtask

  task automatic push_write(input logic [255:0] line);
    for (int i = 0; i < 4; i++) wexp_q.push_back(line[64*i +: 64]);
  endtask

  // Plays memory until n_resp responses arrive; sched bit c lets memory answer in cycle c.
  task automatic serve(input logic [31:0] exp_addr, input int n_resp, input logic [31:0] sched,
                       output int resp_cyc, output logic first_rd);
    int   cyc = 0;
    int   got = 0;
    logic last_rd = 1'b0, seen = 1'b0, held = 1'b1, accept;
    resp_cyc = -1;
    first_rd = 1'b0;
    while (got < n_resp && cyc < 80) begin
      step();
      cyc++;
      pmem_resp = 1'b0;
      accept = (cyc > 31) ? 1'b1 : sched[cyc];
      if (cache_resp) begin
        got++;
        if (got == 1) resp_cyc = cyc;
        chk("pmem_idle_in_done", {254'b0, pmem_read, pmem_write}, 256'b0);
        chk("addr_held", pmem_address, exp_addr);
        if (last_rd) begin
          chk("rdata", cache_rdata, rline_q.pop_front());
          cache_read = 1'b0;
        end else begin
          cache_write = 1'b0;
        end
      end else if (pmem_read || pmem_write) begin
        if (!seen) begin
          seen = 1'b1;
          first_rd = pmem_read;
          chk("pmem_address", pmem_address, exp_addr);
        end
        last_rd = pmem_read;
        if (pmem_read && rbeat_q.size() > 0 && accept) begin
          pmem_resp  = 1'b1;
          pmem_rdata = rbeat_q.pop_front();
        end else if (pmem_write && wexp_q.size() > 0 && accept) begin
          pmem_resp = 1'b1;
          chk("pmem_wdata", pmem_wdata, wexp_q.pop_front());
        end
      end else if (seen && got == 0) begin
        held = 1'b0;
      end
      if (cyc == 2) begin
        cache_addr  = ~cache_addr;
        cache_wdata = ~cache_wdata;
      end
    end
    chk("resp_count", got, n_resp);
    chk("burst_held", held, 1'b1);
    step();
    chk("resp_one_cycle", cache_resp, 1'b0);
  endtask

  initial begin
    int           rc;
    logic         fr;
    logic [255:0] la, lb, lc, ld, lw, lf;

    rst = 1'b1; cache_addr = '0; cache_wdata = '0; cache_read = 1'b0; cache_write = 1'b0;
    pmem_rdata = '0; pmem_resp = 1'b0;
    step(); step();
    chk("rst_resp", cache_resp, 1'b0);
    chk("rst_rw", {pmem_read, pmem_write}, 2'b00);
    chk("rst_addr", pmem_address, 32'h0);
    chk("rst_wdata", pmem_wdata, 64'h0);
    chk("rst_rdata", cache_rdata, 256'h0);
    rst = 1'b0;

    // back-to-back read
    la = mkline(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444);
    push_read(la);
    cache_addr = 32'h0000_1234; cache_read = 1'b1;
    serve(32'h0000_1220, 1, 32'hFFFF_FFFF, rc, fr);
    chk("rd_latency", rc, 5);
    chk("rd_kind", fr, 1'b1);

    // write burst
    lb = mkline(64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
                64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD);
    push_write(lb);
    cache_addr = 32'h8000_0040; cache_wdata = lb; cache_write = 1'b1;
    serve(32'h8000_0040, 1, 32'hFFFF_FFFF, rc, fr);
    chk("wr_latency", rc, 5);
    chk("wr_kind", fr, 1'b0);
    chk("wr_beats_left", wexp_q.size(), 0);
    chk("rdata_stable", cache_rdata, la);

    // read with gaps: beats in cycles 1,4,5,9
    lc = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    push_read(lc);
    cache_addr = 32'h0000_ABC8; cache_read = 1'b1;
    serve(32'h0000_ABC0, 1, 32'h0000_0232, rc, fr);
    chk("gap_latency", rc, 10);

    // read and write together
    ld = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    lw = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    push_read(ld);
    push_write(lw);
    cache_addr = 32'h0000_201F; cache_wdata = lw; cache_read = 1'b1; cache_write = 1'b1;
    serve(32'h0000_2000, 2, 32'hFFFF_FFFF, rc, fr);
    chk("both_read_first", fr, 1'b1);
    chk("both_latency", rc, 5);
    chk("both_wr_beats_left", wexp_q.size(), 0);

    // reset after two read beats
    cache_addr = 32'h0000_4000; cache_read = 1'b1;
    step();
    pmem_resp = 1'b1; pmem_rdata = 64'hDEAD_0000_0000_0001;
    step();
    pmem_rdata = 64'hDEAD_0000_0000_0002;
    step();
    pmem_resp = 1'b0;
    chk("rd_before_rst", pmem_read, 1'b1);
    rst = 1'b1;
    step();
    chk("rst_mid_read", pmem_read, 1'b0);
    chk("rst_mid_resp", cache_resp, 1'b0);
    chk("rst_mid_rdata", cache_rdata, 256'h0);
    rst = 1'b0; cache_read = 1'b0;
    step();
    chk("post_rst_idle", {cache_resp, pmem_read, pmem_write}, 3'b000);
    lf = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    push_read(lf);
    cache_addr = 32'h0000_4010; cache_read = 1'b1;
    serve(32'h0000_4000, 1, 32'hFFFF_FFFF, rc, fr);
    chk("fresh_latency", rc, 5);

    // spurious pmem_resp while idle
    pmem_resp = 1'b1; pmem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("spurious_idle", {cache_resp, pmem_read, pmem_write}, 3'b000);
    end
    pmem_resp = 1'b0;
    chk("spurious_addr", pmem_address, 32'h0000_4000);
    chk("spurious_rdata", cache_rdata, lf);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
